// File: rtl/axis_pattern_source.sv
// axis_pattern_source: AXI4-Stream packet generator emitting seed, seed+1, ... with a ce-counted idle gap.
module axis_pattern_source #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  tvalid,
  input  logic                  tready,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  tlast,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t                state, state_n;
  logic [LEN_WIDTH-1:0]  left, left_n;
  logic [7:0]            gcnt, gcnt_n;
  logic                  tvalid_n, tlast_n, done_n;
  logic [DATA_WIDTH-1:0] tdata_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      left   <= '0;
      gcnt   <= '0;
      tvalid <= 1'b0;
      tdata  <= '0;
      tlast  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      left   <= left_n;
      gcnt   <= gcnt_n;
      tvalid <= tvalid_n;
      tdata  <= tdata_n;
      tlast  <= tlast_n;
      busy   <= state_n != IDLE;
      done   <= done_n;
    end
  end
  // Next values of every output are computed here and registered above, so tready never reaches an output combinationally.
  always_comb begin
    state_n  = state;
    left_n   = left;
    gcnt_n   = gcnt;
    tvalid_n = tvalid;
    tdata_n  = tdata;
    tlast_n  = tlast;
    done_n   = 1'b0;
    case (state)
      IDLE: if (start && ce && pkt_len != '0) begin
        state_n  = SEND;
        left_n   = pkt_len;
        tvalid_n = 1'b1;
        tdata_n  = seed;
        tlast_n  = pkt_len == LEN_WIDTH'(1);
      end
      SEND: if (tready) begin
        if (tlast) begin
          state_n  = (GAP_CYCLES == 0) ? IDLE : GAP;
          gcnt_n   = 8'(GAP_CYCLES);
          tvalid_n = 1'b0;
          tlast_n  = 1'b0;
          done_n   = 1'b1;
        end else begin
          left_n  = left - 1'b1;
          tdata_n = tdata + 1'b1;
          tlast_n = left == LEN_WIDTH'(2);
        end
      end
      GAP: if (ce) begin
        gcnt_n = gcnt - 1'b1;
        if (gcnt == 8'd1) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_axis_pattern_source.sv
// tb_axis_pattern_source: directed scenarios plus a randomized scoreboard run against a beat-list model.
module tb_axis_pattern_source;
  localparam int DW = 16;
  localparam int LW = 8;
  localparam int GC = 2;
  logic          clk = 1'b0;
  logic          rst = 1'b1, ce = 1'b0, start = 1'b0, tready = 1'b0;
  logic [LW-1:0] pkt_len = '0;
  logic [DW-1:0] seed = '0;
  logic          tvalid, tlast, busy, done;
  logic [DW-1:0] tdata;
  int            checks = 0, failures = 0;
  always #5 clk = ~clk;
  axis_pattern_source #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .GAP_CYCLES(GC)) dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start), .pkt_len(pkt_len), .seed(seed),
    .tvalid(tvalid), .tready(tready), .tdata(tdata), .tlast(tlast), .busy(busy), .done(done)
  );
  function automatic logic [DW-1:0] beat(input logic [DW-1:0] s, input int k);
    return DW'((int'(s) + k) % (1 << DW));
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle busy got=%b exp=0", busy);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({tvalid, tlast, busy, done, tdata} !== '0) begin
      failures++;
      $display("FAIL reset tvalid/tlast/busy/done/tdata got=%b%b%b%b/%h exp=0", tvalid, tlast, busy, done, tdata);
    end
    rst = 1'b0;
  endtask
  task automatic test_basic();
    wait_idle();
    ce = 1'b1;
    tready = 1'b1;
    seed = 16'h00FE;
    pkt_len = 8'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({tvalid, tlast, done, tdata} !== {1'b1, k == 3, 1'b0, beat(16'h00FE, k)}) begin
        failures++;
        $display("FAIL basic beat%0d valid/last/done/data got=%b%b%b/%h exp=1%b0/%h", k, tvalid, tlast, done, tdata, k == 3, beat(16'h00FE, k));
      end
      step();
    end
    checks++;
    if ({tvalid, tlast, done, busy} !== 4'b0011) begin
      failures++;
      $display("FAIL basic done_cycle valid/last/done/busy got=%b%b%b%b exp=0011", tvalid, tlast, done, busy);
    end
    step();
    checks++;
    if ({done, busy} !== 2'b01) begin
      failures++;
      $display("FAIL basic gap_cycle done/busy got=%b%b exp=01", done, busy);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL basic gap_end busy got=%b exp=0", busy);
    end
  endtask
  task automatic test_wrap();
    wait_idle();
    seed = 16'hFFFF;
    pkt_len = 8'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({tvalid, tlast, tdata} !== {1'b1, k == 1, beat(16'hFFFF, k)}) begin
        failures++;
        $display("FAIL wrap beat%0d valid/last/data got=%b%b/%h exp=1%b/%h", k, tvalid, tlast, tdata, k == 1, beat(16'hFFFF, k));
      end
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL wrap done got=%b exp=1", done);
    end
  endtask
  task automatic test_stall();
    logic [4:0]    pat;
    logic [DW-1:0] s;
    logic [DW+1:0] pvals;
    logic          pstall;
    int            xfers, dones;
    wait_idle();
    pat = 5'b11001;
    s = DW'($urandom);
    seed = s;
    pkt_len = 8'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    seed = ~s;
    pkt_len = 8'd9;
    xfers = 0;
    dones = 0;
    pstall = 1'b0;
    pvals = '0;
    for (int i = 0; i < 12; i++) begin
      tready = (i < 5) ? pat[i] : 1'b1;
      if (pstall) begin
        checks++;
        if ({tvalid, tlast, tdata} !== pvals) begin
          failures++;
          $display("FAIL stall_hold cycle%0d got=%h exp=%h", i, {tvalid, tlast, tdata}, pvals);
        end
      end
      if (tvalid && tready) begin
        checks++;
        if ({tlast, tdata} !== {xfers == 2, beat(s, xfers)}) begin
          failures++;
          $display("FAIL stall_beat%0d last/data got=%b/%h exp=%b/%h", xfers, tlast, tdata, xfers == 2, beat(s, xfers));
        end
        xfers++;
      end
      dones += int'(done);
      pstall = tvalid && !tready;
      pvals = {tvalid, tlast, tdata};
      step();
    end
    checks++;
    if (xfers !== 3) begin
      failures++;
      $display("FAIL stall_transfers got=%0d exp=3", xfers);
    end
    checks++;
    if (dones !== 1) begin
      failures++;
      $display("FAIL stall_done_count got=%0d exp=1", dones);
    end
  endtask
  task automatic test_ignored_and_single();
    logic [DW-1:0] s;
    wait_idle();
    tready = 1'b1;
    start = 1'b1;
    pkt_len = 8'd3;
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({busy, tvalid, done} !== 3'b000) begin
        failures++;
        $display("FAIL ce_low_start busy/valid/done got=%b%b%b exp=000", busy, tvalid, done);
      end
    end
    ce = 1'b1;
    pkt_len = 8'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({busy, tvalid, done} !== 3'b000) begin
        failures++;
        $display("FAIL zero_len busy/valid/done got=%b%b%b exp=000", busy, tvalid, done);
      end
    end
    s = DW'($urandom);
    seed = s;
    pkt_len = 8'd1;
    step();
    start = 1'b0;
    checks++;
    if ({tvalid, tlast, tdata} !== {2'b11, s}) begin
      failures++;
      $display("FAIL single_beat valid/last/data got=%b%b/%h exp=11/%h", tvalid, tlast, tdata, s);
    end
    step();
    checks++;
    if ({tvalid, done} !== 2'b01) begin
      failures++;
      $display("FAIL single_done valid/done got=%b%b exp=01", tvalid, done);
    end
  endtask
  task automatic test_gap_ce();
    int   d[2];
    int   cyc, first, second, hold;
    logic pv;
    for (int r = 0; r < 2; r++) begin
      wait_idle();
      cyc = 0;
      first = -1;
      second = -1;
      hold = 0;
      pv = 1'b0;
      ce = 1'b1;
      tready = 1'b1;
      pkt_len = 8'd1;
      seed = DW'($urandom);
      start = 1'b1;
      while (second < 0 && cyc < 60) begin
        step();
        cyc++;
        if (r == 1 && done) hold = 3;
        ce = (hold == 0);
        if (hold > 0) hold--;
        if (tvalid && !pv) begin
          if (first < 0) first = cyc;
          else second = cyc;
        end
        pv = tvalid;
      end
      start = 1'b0;
      ce = 1'b1;
      checks++;
      if (second < 0) begin
        failures++;
        $display("FAIL gap_run%0d second packet got=none exp=seen", r);
      end
      d[r] = second - first;
    end
    checks++;
    if (d[0] !== 1 + 1 + GC) begin
      failures++;
      $display("FAIL gap_spacing_ce1 got=%0d exp=%0d", d[0], 1 + 1 + GC);
    end
    checks++;
    if (d[1] !== 1 + 1 + GC + 3) begin
      failures++;
      $display("FAIL gap_spacing_ce_gated got=%0d exp=%0d", d[1], 1 + 1 + GC + 3);
    end
  endtask
  task automatic test_reset_mid();
    logic [DW-1:0] s1, s2;
    int            dones;
    wait_idle();
    s1 = DW'($urandom);
    s2 = DW'($urandom);
    ce = 1'b1;
    tready = 1'b1;
    seed = s1;
    pkt_len = 8'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    checks++;
    if (tdata !== beat(s1, 2)) begin
      failures++;
      $display("FAIL reset_mid beat2 got=%h exp=%h", tdata, beat(s1, 2));
    end
    rst = 1'b1;
    start = 1'b1;
    pkt_len = 8'd7;
    step();
    rst = 1'b0;
    checks++;
    if ({tvalid, tlast, busy, done, tdata} !== '0) begin
      failures++;
      $display("FAIL reset_mid outputs got=%b%b%b%b/%h exp=0", tvalid, tlast, busy, done, tdata);
    end
    seed = s2;
    pkt_len = 8'd3;
    step();
    start = 1'b0;
    dones = 0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({tvalid, tlast, tdata} !== {1'b1, k == 2, beat(s2, k)}) begin
        failures++;
        $display("FAIL reset_mid new beat%0d valid/last/data got=%b%b/%h exp=1%b/%h", k, tvalid, tlast, tdata, k == 2, beat(s2, k));
      end
      dones += int'(done);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      dones += int'(done);
      step();
    end
    checks++;
    if (dones !== 1) begin
      failures++;
      $display("FAIL reset_mid done_count got=%0d exp=1", dones);
    end
  endtask
  task automatic test_random();
    logic [DW:0]   q[$];
    logic [DW:0]   e;
    logic [DW+1:0] pvals;
    logic          pstall, pmid;
    int            accepted, dones, n;
    wait_idle();
    accepted = 0;
    dones = 0;
    pstall = 1'b0;
    pmid = 1'b0;
    pvals = '0;
    for (int i = 0; i < 900; i++) begin
      if (i >= 600 && !busy && q.size() == 0) break;
      start = (i < 600) && ($urandom_range(0, 1) == 1);
      ce = $urandom_range(0, 3) != 0;
      pkt_len = LW'($urandom_range(0, 10));
      seed = DW'($urandom);
      tready = $urandom_range(0, 3) != 0;
      if (pstall) begin
        checks++;
        if ({tvalid, tlast, tdata} !== pvals) begin
          failures++;
          $display("FAIL rand_hold cycle%0d got=%h exp=%h", i, {tvalid, tlast, tdata}, pvals);
        end
      end
      if (pmid) begin
        checks++;
        if (tvalid !== 1'b1) begin
          failures++;
          $display("FAIL rand_bubble cycle%0d tvalid got=%b exp=1", i, tvalid);
        end
      end
      pmid = 1'b0;
      if (tvalid && tready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rand_unexpected_beat got=%h exp=none", tdata);
        end else begin
          e = q.pop_front();
          if ({tlast, tdata} !== e) begin
            failures++;
            $display("FAIL rand_beat last/data got=%b/%h exp=%b/%h", tlast, tdata, e[DW], e[DW-1:0]);
          end
          pmid = !e[DW];
        end
      end
      dones += int'(done);
      pstall = tvalid && !tready;
      pvals = {tvalid, tlast, tdata};
      if (!busy && start && ce && pkt_len != '0) begin
        n = int'(pkt_len);
        for (int k = 0; k < n; k++) q.push_back({k == n - 1, beat(seed, k)});
        accepted++;
      end
      step();
    end
    start = 1'b0;
    ce = 1'b1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL rand_leftover_beats got=%0d exp=0", q.size());
    end
    checks++;
    if (dones !== accepted || accepted == 0) begin
      failures++;
      $display("FAIL rand_done_count got=%0d exp=%0d", dones, accepted);
    end
  endtask
  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_ignored_and_single();
    test_gap_ce();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
